rx_uart_module: RTL and testbench



---
 rtl/rx_uart_module_if.sv | 25 ++
 rtl/rx_uart_module.sv | 156 +++++++++++++++
 tb/tb_rx_uart_module.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rx_uart_module_if.sv
// Serial-line and parallel-result bundle for the UART receiver.
// The master drives the line and enable; the slave (receiver) returns data and strobes.
interface rx_uart_module_if;
    logic       RX_Pin_In;
    logic       Rx_En;
    logic [7:0] Rx_Data;
    logic       Rx_Done_Sig;
    logic       Frame_Err;

    modport master (
        output RX_Pin_In,
        output Rx_En,
        input  Rx_Data,
        input  Rx_Done_Sig,
        input  Frame_Err
    );

    modport slave (
        input  RX_Pin_In,
        input  Rx_En,
        output Rx_Data,
        output Rx_Done_Sig,
        output Frame_Err
    );
endinterface

// File: rtl/rx_uart_module.sv
// UART receiver: 2-FF synchroniser, start-edge detect, mid-bit baud sampler and frame FSM (8N1).
// Define RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module rx_uart_module #(
    parameter int unsigned BPS_MAX = 20833,
    parameter int unsigned BPS_MID = 10416
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    rx_uart_module_if.slave         i_rx
);

    localparam logic [15:0] LP_MAX = 16'(BPS_MAX);
    localparam logic [15:0] LP_MID = 16'(BPS_MID);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      r_state;
    state_t      w_nextState;
    logic        r_rxSync1;
    logic        r_rxSync2;
    logic        r_rxPrev;
    logic [15:0] r_bpsCnt;
    logic [2:0]  r_bitIdx;
    logic [7:0]  r_shift;
    logic [7:0]  r_rxData;
    logic        r_done;
    logic        r_frameErr;
    logic        w_line;
    logic        w_negEdge;
    logic        w_sample;
    logic        w_doneNext;
    logic        w_errNext;
    logic        w_frameOk;
`ifdef RX_PARITY_EN
    logic        r_parityBit;
`endif

    assign w_line    = r_rxSync2;
    assign w_negEdge = r_rxPrev & ~r_rxSync2;
    assign w_sample  = (r_state != IDLE) && (r_bpsCnt == LP_MID);

`ifdef RX_PARITY_EN
    assign w_frameOk = w_line & ~(^{r_shift, r_parityBit});
`else
    assign w_frameOk = w_line;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Dropping the enable aborts any frame; otherwise every decision waits for the mid-bit strobe.
    always_comb begin
        w_nextState = r_state;
        w_doneNext  = 1'b0;
        w_errNext   = 1'b0;
        if (!i_rx.Rx_En) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:   if (w_negEdge) w_nextState = START;
                START:  if (w_sample) w_nextState = w_line ? IDLE : DATA;
                DATA: begin
                    if (w_sample && (r_bitIdx == 3'd7)) begin
`ifdef RX_PARITY_EN
                        w_nextState = PARITY;
`else
                        w_nextState = STOP;
`endif
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: if (w_sample) w_nextState = STOP;
`endif
                STOP: begin
                    if (w_sample) begin
                        w_nextState = IDLE;
                        w_doneNext  = w_frameOk;
                        w_errNext   = ~w_frameOk;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rxSync1 <= 1'b1;
            r_rxSync2 <= 1'b1;
            r_rxPrev  <= 1'b1;
        end else begin
            r_rxSync1 <= i_rx.RX_Pin_In;
            r_rxSync2 <= r_rxSync1;
            r_rxPrev  <= r_rxSync2;
        end
    end

    // Counter restarts from zero whenever the FSM is in or re-entering IDLE, so START always begins at 0.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_bpsCnt <= 16'd0;
        end else if ((r_state == IDLE) || (w_nextState == IDLE) || (r_bpsCnt == LP_MAX)) begin
            r_bpsCnt <= 16'd0;
        end else begin
            r_bpsCnt <= r_bpsCnt + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_bitIdx <= 3'd0;
            r_shift  <= 8'h00;
        end else if (r_state == START) begin
            r_bitIdx <= 3'd0;
        end else if ((r_state == DATA) && w_sample) begin
            r_shift[r_bitIdx] <= w_line;
            r_bitIdx          <= r_bitIdx + 3'd1;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_parityBit <= 1'b0;
        end else if ((r_state == PARITY) && w_sample) begin
            r_parityBit <= w_line;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rxData   <= 8'h00;
            r_done     <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_done     <= w_doneNext;
            r_frameErr <= w_errNext;
            if (w_doneNext) r_rxData <= r_shift;
        end
    end

    assign i_rx.Rx_Data     = r_rxData;
    assign i_rx.Rx_Done_Sig = r_done;
    assign i_rx.Frame_Err   = r_frameErr;

endmodule

// File: tb/tb_rx_uart_module.sv
// Scoreboard bench for rx_uart_module: frames are modelled as bit lists, expected pulses queued,
// and a free-running monitor pops and compares every done/error strobe (data, kind, latency).
module tb_rx_uart_module;

    localparam int BIT_CYC = 16;

    typedef struct {
        bit         isErr;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    int   cycleCnt = 0;
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   pulsesSeen = 0;
    logic [7:0] lastGood = 8'h00;
    exp_t expQ[$];

    rx_uart_module_if bus ();

    rx_uart_module #(.BPS_MAX(15), .BPS_MID(7)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .i_rx (bus.slave)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cycleCnt);
        end
    endtask

    task automatic idle(input int n);
        bus.RX_Pin_In = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Sends one frame; abortBit drops Rx_En at that bit, resetBit pulses RSTn at that bit.
    task automatic applyStimulus(input logic [7:0] data, input bit stopBit, input bit parityBit,
                                 input int abortBit, input int resetBit);
        bit   bits[$];
        bit   good;
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef RX_PARITY_EN
        bits.push_back(parityBit);
        good = stopBit && ((($countones(data) + int'(parityBit)) % 2) == 0);
`else
        good = stopBit;
`endif
        bits.push_back(stopBit);
        if (abortBit < 0 && resetBit < 0) begin
            if (good) lastGood = data;
            e.isErr = !good;
            e.data  = lastGood;
            e.due   = cycleCnt + (bits.size() - 1) * BIT_CYC + 7 + 4;
            expQ.push_back(e);
            pushed++;
        end
        for (int i = 0; i < bits.size(); i++) begin
            if (i == abortBit) bus.Rx_En = 1'b0;
            if (i == resetBit) begin
                bus.RX_Pin_In = 1'b1;
                RSTn = 1'b0;
                @(negedge CLK);
                lastGood = 8'h00;
                checkOutput("reset_rx_data", int'(bus.Rx_Data), 0);
                checkOutput("reset_done", int'(bus.Rx_Done_Sig), 0);
                checkOutput("reset_err", int'(bus.Frame_Err), 0);
                repeat (2) @(negedge CLK);
                RSTn = 1'b1;
                idle(20);
                return;
            end
            bus.RX_Pin_In = bits[i];
            repeat (BIT_CYC) @(negedge CLK);
        end
        if (abortBit >= 0) begin
            idle(20);
            bus.Rx_En = 1'b1;
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RSTn && (bus.Rx_Done_Sig || bus.Frame_Err)) begin
                pulsesSeen++;
                checkOutput("pulses_exclusive", int'(bus.Rx_Done_Sig & bus.Frame_Err), 0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", int'(bus.Frame_Err), -1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pulse_kind_err", int'(bus.Frame_Err), int'(e.isErr));
                    checkOutput("pulse_kind_done", int'(bus.Rx_Done_Sig), int'(!e.isErr));
                    checkOutput("rx_data", int'(bus.Rx_Data), int'(e.data));
                    checkOutput("latency_cycle_window",
                                int'((cycleCnt >= e.due - 1) && (cycleCnt <= e.due + 1)), 1);
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        bit         sb;
        bit         pb;
        bus.RX_Pin_In = 1'b1;
        bus.Rx_En     = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("por_rx_data", int'(bus.Rx_Data), 0);
        checkOutput("por_done", int'(bus.Rx_Done_Sig), 0);
        checkOutput("por_err", int'(bus.Frame_Err), 0);
        RSTn = 1'b1;
        idle(10);

        $display("[TB] nominal 0xA5");
        applyStimulus(8'hA5, 1'b1, ^8'hA5, -1, -1);
        idle(10);

        $display("[TB] false start then 0x3C");
        bus.RX_Pin_In = 1'b0;
        repeat (4) @(negedge CLK);
        idle(40);
        applyStimulus(8'h3C, 1'b1, ^8'h3C, -1, -1);
        idle(10);

        $display("[TB] framing error 0x5A");
        applyStimulus(8'h5A, 1'b0, ^8'h5A, -1, -1);
        idle(10);

        $display("[TB] back-to-back 0x00 0xFF");
        applyStimulus(8'h00, 1'b1, 1'b0, -1, -1);
        applyStimulus(8'hFF, 1'b1, 1'b0, -1, -1);
        idle(10);

        $display("[TB] enable abort and reset mid-frame");
        applyStimulus(8'h81, 1'b1, ^8'h81, 4, -1);
        applyStimulus(8'h81, 1'b1, ^8'h81, -1, 5);
        applyStimulus(8'h81, 1'b1, ^8'h81, -1, -1);
        idle(10);

        $display("[TB] break condition");
        applyStimulus(8'h00, 1'b0, 1'b0, -1, -1);
        bus.RX_Pin_In = 1'b0;
        repeat (200) @(negedge CLK);
        idle(20);

`ifdef RX_PARITY_EN
        $display("[TB] parity 0x07");
        applyStimulus(8'h07, 1'b1, 1'b1, -1, -1);
        idle(10);
        applyStimulus(8'h07, 1'b1, 1'b0, -1, -1);
        idle(10);
`endif

        $display("[TB] random frames");
        for (int n = 0; n < 16; n++) begin
            d  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 4) != 0);
            pb = (^d) ^ ($urandom_range(0, 4) == 0);
            applyStimulus(d, sb, pb, -1, -1);
            idle(sb ? $urandom_range(0, 12) : $urandom_range(4, 12));
        end

        for (int t = 0; t < 500 && expQ.size() != 0; t++) @(negedge CLK);
        idle(40);
        checkOutput("queue_drained", expQ.size(), 0);
        checkOutput("pulse_count", pulsesSeen, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
